// File: rtl/vector_stream_buffer_pkg.sv
// Shared types for the inter-layer vector stream buffer.
package vector_stream_buffer_pkg;

  localparam int WIDTH = 16;

  typedef logic signed [WIDTH-1:0] elem_t;

  // Write side: which bank is being filled, or stalled because both banks are full.
  typedef enum logic [1:0] {
    FILL_BANK0,
    FILL_BANK1,
    FILL_STALL
  } fill_state_t;

  // Read side: which bank is being replayed, or idle waiting for a complete vector.
  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_BANK0,
    DRAIN_BANK1
  } drain_state_t;

endpackage

// File: rtl/vector_stream_buffer_if.sv
// Streaming element interface: upstream s_* side and downstream m_* side.
interface vector_stream_buffer_if #(
  parameter int WIDTH = 16
);

  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] data_in;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [WIDTH-1:0] data_out;

  // Buffer view: consumes the upstream stream, produces the downstream stream.
  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, data_out
  );

  // Environment view: drives upstream elements and downstream acceptance.
  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, data_out
  );

endinterface

// File: rtl/vector_stream_buffer_bank_mem.sv
// Two-bank element storage: one synchronous write port, one combinational read port.
module pingpong_bank_mem #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2][DEPTH];

  // Store one element per accepted upstream beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/vector_stream_buffer.sv
// Ping-pong vector buffer: fills one bank while the other is replayed REPLAY times.
module vector_stream_buffer
  import vector_stream_buffer_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int REPLAY = 1
) (
  input logic                  clk,
  input logic                  reset,
  vector_stream_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(REPLAY) + 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(REPLAY - 1);

  logic [1:0]       full;
  logic             wbank;
  logic             rbank;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [PW-1:0]    pass;
  logic             m_valid_r;
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] rd_data;

  fill_state_t  fill_state;
  drain_state_t drain_state;
  logic         accept;
  logic         load;

  // The FSM states are views of the bank flags, so full[]/wbank/rbank stay the only state.
  always_comb begin
    fill_state  = FILL_STALL;
    drain_state = DRAIN_IDLE;
    if (!full[wbank]) begin
      fill_state = wbank ? FILL_BANK1 : FILL_BANK0;
    end
    if (full[rbank]) begin
      drain_state = rbank ? DRAIN_BANK1 : DRAIN_BANK0;
    end
  end

  assign bus.s_ready = (fill_state != FILL_STALL);
  assign accept      = bus.s_valid && (fill_state != FILL_STALL) && !reset;
  assign load        = (drain_state != DRAIN_IDLE) && (!m_valid_r || bus.m_ready) && !reset;

  pingpong_bank_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (accept),
    .wr_bank (wbank),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_bank (rbank),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Fill and drain sequencing plus the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      full       <= '0;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass       <= '0;
      m_valid_r  <= 1'b0;
      data_out_r <= '0;
    end else begin
      if (accept) begin
        if (wr_ptr == LAST_ADDR) begin
          wr_ptr       <= '0;
          full[wbank]  <= 1'b1;
          wbank        <= ~wbank;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end

      // Fill only sets a non-full bank and drain only clears a full one,
      // so these two writes to full[] never collide.
      if (load) begin
        data_out_r <= rd_data;
        m_valid_r  <= 1'b1;
        if (rd_ptr == LAST_ADDR) begin
          rd_ptr <= '0;
          if (pass == LAST_PASS) begin
            pass        <= '0;
            full[rbank] <= 1'b0;
            rbank       <= ~rbank;
          end else begin
            pass <= pass + PW'(1);
          end
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end else if (bus.m_ready) begin
        m_valid_r <= 1'b0;
      end
    end
  end

  assign bus.m_valid  = m_valid_r;
  assign bus.data_out = data_out_r;

endmodule
